// File: rtl/adc_ltc2308_sampler_if.sv
// Bus bundle between the LTC2308 sampler and its surroundings: ADC SPI pins,
// run enable, and the sample output that feeds the sensor PIO in_port.
interface adc_ltc2308_sampler_if;
    logic        enable;
    logic        adc_convst;
    logic        adc_sck;
    logic        adc_sdi;
    logic        adc_sdo;
    logic [11:0] data_out;
    logic        data_valid;
    logic        overrun;

    modport master (
        input  enable, adc_sdo,
        output adc_convst, adc_sck, adc_sdi, data_out, data_valid, overrun
    );

    modport slave (
        output enable, adc_sdo,
        input  adc_convst, adc_sck, adc_sdi, data_out, data_valid, overrun
    );
endinterface

// File: rtl/adc_ltc2308_sampler.sv
// Periodic SPI master for an LTC2308-class 12-bit SAR ADC; holds the latest sample.
// Optional 4-sample box average enabled by defining ADC_AVG4_EN.
module adc_ltc2308_sampler #(
    parameter int CLK_DIV       = 2,
    parameter int CONV_CYCLES   = 80,
    parameter int SAMPLE_PERIOD = 2500,
    parameter int CHANNEL       = 0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    adc_ltc2308_sampler_if.master        bus
);
    localparam int TICK_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int CONV_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [2:0]  CH  = 3'(CHANNEL);
    // S/D, O/S, S1, S0, UNI, SLP, then six don't-care slots driven low
    localparam logic [11:0] CFG = {1'b1, CH[0], CH[2], CH[1], 1'b1, 1'b0, 6'b0};

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

    state_t            state, state_nxt;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [CONV_W-1:0] conv_cnt, conv_cnt_nxt;
    logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
    logic              half, half_nxt;
    logic [3:0]        bit_idx, bit_idx_nxt;
    logic              rise;
    logic              load;
    logic [11:0]       shift_q;
    logic              convst_q, sck_q, sdi_q, valid_q, overrun_q;
    logic [11:0]       data_q;

    assign tick = bus.enable && (tick_cnt == TICK_W'(SAMPLE_PERIOD - 1));
    assign load = (state_nxt == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt  <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (!bus.enable || tick) tick_cnt <= '0;
            else                     tick_cnt <= tick_cnt + 1'b1;
            if (!bus.enable)                   overrun_q <= 1'b0;
            else if (tick && state != IDLE)    overrun_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            conv_cnt <= '0;
            div_cnt  <= '0;
            half     <= 1'b0;
            bit_idx  <= '0;
        end else begin
            state    <= state_nxt;
            conv_cnt <= conv_cnt_nxt;
            div_cnt  <= div_cnt_nxt;
            half     <= half_nxt;
            bit_idx  <= bit_idx_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        conv_cnt_nxt = conv_cnt;
        div_cnt_nxt  = div_cnt;
        half_nxt     = half;
        bit_idx_nxt  = bit_idx;
        rise         = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_nxt    = CONV;
                    conv_cnt_nxt = '0;
                end
            end
            CONV: begin
                if (conv_cnt == CONV_W'(CONV_CYCLES - 1)) begin
                    state_nxt   = SHIFT;
                    div_cnt_nxt = '0;
                    half_nxt    = 1'b0;
                    bit_idx_nxt = '0;
                end else begin
                    conv_cnt_nxt = conv_cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                    div_cnt_nxt = '0;
                    half_nxt    = ~half;
                    if (!half) begin
                        rise = 1'b1;
                    end else if (bit_idx == 4'd11) begin
                        state_nxt = DONE;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end else begin
                    div_cnt_nxt = div_cnt + 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pins are registered from next-state values so they line up with the state
    // register and never glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            convst_q <= 1'b0;
            sck_q    <= 1'b0;
            sdi_q    <= 1'b0;
            shift_q  <= '0;
        end else begin
            convst_q <= (state_nxt == CONV);
            sck_q    <= (state_nxt == SHIFT) && half_nxt;
            sdi_q    <= (state_nxt == SHIFT) && CFG[4'd11 - bit_idx_nxt];
            if (rise) shift_q <= {shift_q[10:0], bus.adc_sdo};
        end
    end

`ifdef ADC_AVG4_EN
    logic [13:0] acc;
    logic [1:0]  avg_cnt;
    logic [13:0] sum;

    assign sum = acc + {2'b00, shift_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            avg_cnt <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!bus.enable) begin
                acc     <= '0;
                avg_cnt <= '0;
            end else if (load) begin
                if (avg_cnt == 2'd3) begin
                    data_q  <= sum[13:2];
                    valid_q <= 1'b1;
                    acc     <= '0;
                    avg_cnt <= '0;
                end else begin
                    acc     <= sum;
                    avg_cnt <= avg_cnt + 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= load;
            if (load) data_q <= shift_q;
        end
    end
`endif

    assign bus.adc_convst = convst_q;
    assign bus.adc_sck    = sck_q;
    assign bus.adc_sdi    = sdi_q;
    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_adc_ltc2308_sampler.sv
// Directed bench for adc_ltc2308_sampler: two instances (CHANNEL 5 at the default
// rate, CHANNEL 2 at a 100-cycle rate) with a behavioural LTC2308 SDO model each.
module tb_adc_ltc2308_sampler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_a, rst_n_b, en_a, en_b;
    logic        sdo_a = 1'b0, sdo_b = 1'b0;
    logic [11:0] word_a, word_b, cur_a, cur_b;
    int          idx_a = -1, idx_b = -1;
    int          checks = 0, failures = 0;
    int          cyc = 0;

    adc_ltc2308_sampler_if ifa ();
    adc_ltc2308_sampler_if ifb ();
    assign ifa.enable  = en_a;
    assign ifa.adc_sdo = sdo_a;
    assign ifb.enable  = en_b;
    assign ifb.adc_sdo = sdo_b;

    adc_ltc2308_sampler #(.CHANNEL(5)) u_a (.clk(clk), .reset_n(rst_n_a), .bus(ifa));
    adc_ltc2308_sampler #(.SAMPLE_PERIOD(100), .CHANNEL(2)) u_b (.clk(clk), .reset_n(rst_n_b), .bus(ifb));

    always @(posedge clk) cyc <= cyc + 1;

`ifdef ADC_AVG4_EN
    logic [11:0] avg_seq [4] = '{12'h100, 12'h200, 12'h300, 12'h403};
    int          mi_a = 0;
`endif

    // ADC model: MSB appears when CONVST falls, later bits on each SCK fall
    always @(negedge ifa.adc_convst) if (rst_n_a === 1'b1) begin
`ifdef ADC_AVG4_EN
        cur_a = avg_seq[mi_a % 4];
        mi_a++;
`else
        cur_a = word_a;
`endif
        sdo_a = cur_a[11];
        idx_a = 10;
    end
    always @(negedge ifa.adc_sck) if (idx_a >= 0) begin
        sdo_a = cur_a[idx_a];
        idx_a--;
    end
    always @(negedge ifb.adc_convst) if (rst_n_b === 1'b1) begin
        cur_b = word_b;
        sdo_b = cur_b[11];
        idx_b = 10;
    end
    always @(negedge ifb.adc_sck) if (idx_b >= 0) begin
        sdo_b = cur_b[idx_b];
        idx_b--;
    end

    logic        cv_p_a = 1'b0, sck_p_a = 1'b0, cv_p_b = 1'b0, sck_p_b = 1'b0;
    int          conv_rise_a = 0, hi_a = 0, rises_a = 0, first_rise_a = 0, last_rise_a = 0;
    int          valid_cyc_a = 0, nvalid_a = 0, nconv_a = 0;
    logic [11:0] sdi_a = '0, sdi_b = '0;

    always @(negedge clk) begin
        if (ifa.adc_convst && !cv_p_a) begin
            conv_rise_a <= cyc;
            hi_a        <= 1;
            rises_a     <= 0;
            sdi_a       <= '0;
            nconv_a     <= nconv_a + 1;
        end else if (ifa.adc_convst) begin
            hi_a <= hi_a + 1;
        end
        if (ifa.adc_sck && !sck_p_a) begin
            if (rises_a == 0) first_rise_a <= cyc;
            last_rise_a <= cyc;
            rises_a     <= rises_a + 1;
            sdi_a       <= {sdi_a[10:0], ifa.adc_sdi};
        end
        if (ifa.data_valid) begin
            valid_cyc_a <= cyc;
            nvalid_a    <= nvalid_a + 1;
        end
        cv_p_a  <= ifa.adc_convst;
        sck_p_a <= ifa.adc_sck;
    end

    always @(negedge clk) begin
        if (ifb.adc_convst && !cv_p_b) sdi_b <= '0;
        else if (ifb.adc_sck && !sck_p_b) sdi_b <= {sdi_b[10:0], ifb.adc_sdi};
        cv_p_b  <= ifb.adc_convst;
        sck_p_b <= ifb.adc_sck;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input bit sel_b, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #1;
            if (sel_b ? ifb.data_valid : ifa.data_valid) ok = 1'b1;
        end
    endtask

    bit ok;
    int nv, nc;

    initial begin
        rst_n_a = 1'b0; rst_n_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
        word_a = 12'hA5C; word_b = 12'h5A3;
        repeat (3) @(negedge clk); #1;
        chk("rst_a", {ifa.adc_convst, ifa.adc_sck, ifa.adc_sdi, ifa.data_valid, ifa.overrun, ifa.data_out}, 0);
        chk("rst_b", {ifb.adc_convst, ifb.adc_sck, ifb.adc_sdi, ifb.data_valid, ifb.overrun, ifb.data_out}, 0);
        rst_n_a = 1'b1; rst_n_b = 1'b1; en_a = 1'b1; en_b = 1'b1;

        // Instance b: 100-cycle rate, so the next tick lands inside SHIFT
        wait_valid(1'b1, 1500, ok);
        chk("b_valid_seen", ok, 1);
        chk("b_data", ifb.data_out, 12'h5A3);
        chk("b_overrun_set", ifb.overrun, 1);
        chk("b_sdi_cfg_ch2", sdi_b, 12'h980);
        @(negedge clk); #1;
        chk("b_valid_pulse", ifb.data_valid, 0);
        en_b = 1'b0;
        @(negedge clk); #1;
        chk("b_overrun_clr", ifb.overrun, 0);
        en_b = 1'b1;
        word_b = 12'h0F0;
        wait_valid(1'b1, 1500, ok);
        chk("b_valid2_seen", ok, 1);
        chk("b_data2", ifb.data_out, 12'h0F0);
        chk("b_overrun_set2", ifb.overrun, 1);

`ifndef ADC_AVG4_EN
        // Instance a: basic conversion timing and config word
        wait_valid(1'b0, 3000, ok);
        chk("a_valid_seen", ok, 1);
        chk("a_data", ifa.data_out, 12'hA5C);
        chk("a_latency", valid_cyc_a - conv_rise_a, 128);
        chk("a_convst_width", hi_a, 80);
        chk("a_sck_count", rises_a, 12);
        chk("a_sck_span", last_rise_a - first_rise_a, 44);
        chk("a_sdi_cfg_ch5", sdi_a, 12'hE80);
        @(negedge clk); #1;
        chk("a_valid_pulse", ifa.data_valid, 0);

        // Reset in the middle of SHIFT
        word_a = 12'h3FF;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk); #1;
            if (rises_a == 6 && ifa.adc_sck) ok = 1'b1;
        end
        chk("a_sck6_reached", ok, 1);
        rst_n_a = 1'b0; #1;
        chk("a_rst_mid_shift", {ifa.adc_convst, ifa.adc_sck, ifa.adc_sdi, ifa.data_valid, ifa.overrun, ifa.data_out}, 0);
        repeat (2) @(negedge clk);
        rst_n_a = 1'b1;
        wait_valid(1'b0, 3000, ok);
        chk("a_post_rst_valid", ok, 1);
        chk("a_post_rst_data", ifa.data_out, 12'h3FF);
        chk("a_post_rst_latency", valid_cyc_a - conv_rise_a, 128);

        // Enable dropped during CONV
        word_a = 12'h7E1;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk); #1;
            if (ifa.adc_convst) ok = 1'b1;
        end
        chk("a_conv_started", ok, 1);
        en_a = 1'b0;
        nv = nvalid_a;
        wait_valid(1'b0, 300, ok);
        chk("a_drop_valid", ok, 1);
        chk("a_drop_data", ifa.data_out, 12'h7E1);
        nc = nconv_a;
        repeat (7500) @(negedge clk); #1;
        chk("a_drop_no_conv", nconv_a, nc);
        chk("a_drop_one_valid", nvalid_a, nv + 1);
        chk("a_drop_convst_low", ifa.adc_convst, 0);
`else
        // Instance a: four-sample average
        ok = 1'b0;
        for (int i = 0; i < 12000 && !ok; i++) begin
            @(negedge clk); #1;
            if (nconv_a == 4) ok = 1'b1;
        end
        chk("avg_conv4_reached", ok, 1);
        chk("avg_no_early_valid", nvalid_a, 0);
        chk("avg_data_held", ifa.data_out, 12'h000);
        wait_valid(1'b0, 300, ok);
        chk("avg_valid_seen", ok, 1);
        chk("avg_data", ifa.data_out, 12'h280);
        chk("avg_one_valid", nvalid_a, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
